// File: rtl/c_mem_stage_pkg.sv
// Shared types and lane helpers for the memory stage of the 32-bit RISC-V pipeline.
package c_mem_stage_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned BE_W   = XLEN / 8;

  localparam logic [1:0] MEM_SIZE_B = 2'b00;
  localparam logic [1:0] MEM_SIZE_H = 2'b01;
  localparam logic [1:0] MEM_SIZE_W = 2'b10;

  typedef enum logic [0:0] {
    C_IDLE = 1'b0,
    C_BUSY = 1'b1
  } mem_state_e;

  // Request payload held stable on the data-memory port while BUSY
  typedef struct packed {
    logic              we;
    logic [XLEN-1:0]   addr;
    logic [BE_W-1:0]   be;
    logic [XLEN-1:0]   wdata;
  } dmem_req_t;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [REG_AW-1:0] write_sel;
    logic              is_load;
    logic              is_wb;
    logic [1:0]        size;
    logic              uns;
    logic [1:0]        addr_lo;
  } mem_ctx_t;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [REG_AW-1:0] write_sel;
    logic              is_wb;
    logic [XLEN-1:0]   result;
  } cw_bundle_t;

  function automatic logic [BE_W-1:0] store_be(input logic [1:0] size, input logic [1:0] a);
    logic [BE_W-1:0] be;
    case (size)
      MEM_SIZE_B: be = BE_W'(1) << a;
      MEM_SIZE_H: be = a[1] ? 4'b1100 : 4'b0011;
      default:    be = '1;
    endcase
    return be;
  endfunction

  function automatic logic [XLEN-1:0] store_wdata(input logic [1:0] size, input logic [XLEN-1:0] d);
    logic [XLEN-1:0] w;
    case (size)
      MEM_SIZE_B: w = {4{d[7:0]}};
      MEM_SIZE_H: w = {2{d[15:0]}};
      default:    w = d;
    endcase
    return w;
  endfunction

  function automatic logic addr_misaligned(input logic [1:0] size, input logic [1:0] a);
    logic m;
    case (size)
      MEM_SIZE_B: m = 1'b0;
      MEM_SIZE_H: m = a[0];
      default:    m = (a != 2'b00);
    endcase
    return m;
  endfunction

endpackage

// File: rtl/c_load_align.sv
// Load lane select and sign/zero extension from a 32-bit memory word.
module c_load_align
  import c_mem_stage_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      addr_lo,
  input  logic [1:0]      size,
  input  logic            uns,
  output logic [XLEN-1:0] data_c
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = rdata[7:0];
    half_lane = rdata[15:0];
    case (addr_lo)
      2'd1:    byte_lane = rdata[15:8];
      2'd2:    byte_lane = rdata[23:16];
      2'd3:    byte_lane = rdata[31:24];
      default: byte_lane = rdata[7:0];
    endcase
    // Half lane is chosen by addr bit 1 only; bit 0 never splits a halfword
    if (addr_lo[1]) half_lane = rdata[31:16];
    case (size)
      MEM_SIZE_B: data_c = {{24{~uns & byte_lane[7]}}, byte_lane};
      MEM_SIZE_H: data_c = {{16{~uns & half_lane[15]}}, half_lane};
      default:    data_c = rdata;
    endcase
  end

endmodule

// File: rtl/c_mem_stage.sv
// Memory stage: ALU ops pass through in one cycle; loads/stores use a req/ack data port.
// Optional misaligned-access trap enabled by `C_MISALIGN_CHECK_EN.
module c_mem_stage
  import c_mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [XLEN-1:0]   ac_pc,
  input  logic [REG_AW-1:0] ac_write_sel,
  input  logic              ac_is_load,
  input  logic              ac_is_store,
  input  logic              ac_is_wb,
  input  logic [1:0]        ac_mem_size,
  input  logic              ac_mem_uns,
  input  logic [XLEN-1:0]   ALU_result,
  input  logic [XLEN-1:0]   ac_store_data,
  output logic              mem_stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [BE_W-1:0]   dmem_be,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic              dmem_ack,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic [XLEN-1:0]   cw_pc,
  output logic [REG_AW-1:0] cw_write_sel,
  output logic              cw_is_wb,
  output logic [XLEN-1:0]   cw_result,
  output logic              cw_err,
  output logic              cw_misalign
);

  localparam int unsigned CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned CNT_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  mem_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  dmem_req_t        req_q, req_d;
  mem_ctx_t         ctx_q, ctx_d;
  cw_bundle_t       cw_q, cw_d;
  logic             err_q, err_d;
  logic             mis_q, mis_d;
  logic             stall;
  logic             mem_op;
  logic             misaligned;
  logic             timeout;
  logic [XLEN-1:0]  load_data_c;

  c_load_align u_load_align (
    .rdata   (dmem_rdata),
    .addr_lo (ctx_q.addr_lo),
    .size    (ctx_q.size),
    .uns     (ctx_q.uns),
    .data_c  (load_data_c)
  );

  assign mem_op = ac_is_load | ac_is_store;

`ifdef C_MISALIGN_CHECK_EN
  assign misaligned = mem_op & addr_misaligned(ac_mem_size, ALU_result[1:0]);
`else
  assign misaligned = 1'b0;
`endif

  // A zero timeout disables the abort entirely
  assign timeout = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(CNT_LAST));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= C_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      ctx_q   <= '0;
      cw_q    <= '0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      ctx_q   <= ctx_d;
      cw_q    <= cw_d;
      err_q   <= err_d;
      mis_q   <= mis_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    ctx_d   = ctx_q;
    cw_d    = cw_q;
    err_d   = 1'b0;
    mis_d   = 1'b0;
    stall   = 1'b0;
    case (state_q)
      C_IDLE: begin
        cnt_d = '0;
        if (misaligned) begin
          mis_d       = 1'b1;
          cw_d.is_wb  = 1'b0;
        end else if (mem_op) begin
          stall         = 1'b1;
          state_d       = C_BUSY;
          req_d.we      = ac_is_store;
          req_d.addr    = {ALU_result[XLEN-1:2], 2'b00};
          req_d.be      = store_be(ac_mem_size, ALU_result[1:0]);
          req_d.wdata   = store_wdata(ac_mem_size, ac_store_data);
          ctx_d.pc        = ac_pc;
          ctx_d.write_sel = ac_write_sel;
          ctx_d.is_load   = ac_is_load;
          ctx_d.is_wb     = ac_is_wb;
          ctx_d.size      = ac_mem_size;
          ctx_d.uns       = ac_mem_uns;
          ctx_d.addr_lo   = ALU_result[1:0];
          cw_d.is_wb      = 1'b0;
        end else begin
          cw_d.pc        = ac_pc;
          cw_d.write_sel = ac_write_sel;
          cw_d.is_wb     = ac_is_wb;
          cw_d.result    = ALU_result;
        end
      end
      C_BUSY: begin
        stall = ~dmem_ack;
        cnt_d = cnt_q + CNT_W'(1);
        // Ack takes priority over a timeout landing in the same cycle
        if (dmem_ack) begin
          state_d        = C_IDLE;
          cnt_d          = '0;
          cw_d.pc        = ctx_q.pc;
          cw_d.write_sel = ctx_q.write_sel;
          cw_d.is_wb     = ctx_q.is_wb & ctx_q.is_load;
          cw_d.result    = load_data_c;
        end else if (timeout) begin
          stall      = 1'b0;
          state_d    = C_IDLE;
          cnt_d      = '0;
          err_d      = 1'b1;
          cw_d.is_wb = 1'b0;
        end
      end
      default: state_d = C_IDLE;
    endcase
  end

  // Stall is combinational toward execute; forced low while reset is asserted
  assign mem_stall    = stall & reset;
  assign dmem_req     = (state_q == C_BUSY);
  assign dmem_we      = req_q.we;
  assign dmem_addr    = req_q.addr;
  assign dmem_be      = req_q.be;
  assign dmem_wdata   = req_q.wdata;
  assign cw_pc        = cw_q.pc;
  assign cw_write_sel = cw_q.write_sel;
  assign cw_is_wb     = cw_q.is_wb;
  assign cw_result    = cw_q.result;
  assign cw_err       = err_q;
  assign cw_misalign  = mis_q;

endmodule

// File: tb/tb_c_mem_stage.sv
// Randomized bench for c_mem_stage against a transaction-level reference model.
module tb_c_mem_stage;

  localparam int unsigned TO     = 16;
  localparam int          NO_ACK = 1000;
  localparam logic [1:0]  SZ_B   = 2'b00;
  localparam logic [1:0]  SZ_H   = 2'b01;
  localparam logic [1:0]  SZ_W   = 2'b10;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] ac_pc;
  logic [4:0]  ac_write_sel;
  logic        ac_is_load;
  logic        ac_is_store;
  logic        ac_is_wb;
  logic [1:0]  ac_mem_size;
  logic        ac_mem_uns;
  logic [31:0] ALU_result;
  logic [31:0] ac_store_data;
  logic        mem_stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic [31:0] cw_pc;
  logic [4:0]  cw_write_sel;
  logic        cw_is_wb;
  logic [31:0] cw_result;
  logic        cw_err;
  logic        cw_misalign;

  int n_tests = 0;
  int n_fail  = 0;

  c_mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clock         (clock),
    .reset         (reset),
    .ac_pc         (ac_pc),
    .ac_write_sel  (ac_write_sel),
    .ac_is_load    (ac_is_load),
    .ac_is_store   (ac_is_store),
    .ac_is_wb      (ac_is_wb),
    .ac_mem_size   (ac_mem_size),
    .ac_mem_uns    (ac_mem_uns),
    .ALU_result    (ALU_result),
    .ac_store_data (ac_store_data),
    .mem_stall     (mem_stall),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_be       (dmem_be),
    .dmem_wdata    (dmem_wdata),
    .dmem_ack      (dmem_ack),
    .dmem_rdata    (dmem_rdata),
    .cw_pc         (cw_pc),
    .cw_write_sel  (cw_write_sel),
    .cw_is_wb      (cw_is_wb),
    .cw_result     (cw_result),
    .cw_err        (cw_err),
    .cw_misalign   (cw_misalign)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] load_model(input logic [31:0] w, input logic [1:0] size,
                                             input logic [1:0] a, input logic uns);
    logic [31:0] v;
    case (size)
      SZ_B: begin
        v = (w >> (8 * int'(a))) & 32'hFF;
        if (!uns && v >= 32'h80) v = v + 32'hFFFF_FF00;
      end
      SZ_H: begin
        v = (w >> (16 * (int'(a) / 2))) & 32'hFFFF;
        if (!uns && v >= 32'h8000) v = v + 32'hFFFF_0000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] be_model(input logic [1:0] size, input logic [1:0] a);
    logic [3:0] be;
    case (size)
      SZ_B:    be = 4'b0001 << a;
      SZ_H:    be = (a >= 2'd2) ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] wdata_model(input logic [1:0] size, input logic [31:0] d);
    logic [31:0] w;
    case (size)
      SZ_B:    w = 32'(d[7:0]) * 32'h0101_0101;
      SZ_H:    w = 32'(d[15:0]) * 32'h0001_0001;
      default: w = d;
    endcase
    return w;
  endfunction

  // One instruction held in execute until the stage stops stalling, then one idle op
  task automatic do_op(input logic [31:0] pc, input logic [4:0] sel, input logic ld, input logic st,
                       input logic wb, input logic [1:0] size, input logic uns,
                       input logic [31:0] res, input logic [31:0] sdata,
                       input int lat, input logic [31:0] rdata);
    int stall_cnt, req_cnt, cyc, exp_cnt;
    bit done, mem, mis, timed_out;
    logic [1:0]  a;
    logic [31:0] npc, nres;
    logic [4:0]  nsel;
    mem = ld | st;
    a   = res[1:0];
    mis = 1'b0;
`ifdef C_MISALIGN_CHECK_EN
    mis = mem && ((size == SZ_H && a[0]) || (size == SZ_W && a != 2'b00));
`endif
    timed_out = mem && !mis && (lat >= int'(TO));
    exp_cnt   = (!mem || mis) ? 0 : (timed_out ? int'(TO) : lat + 1);

    ac_pc = pc; ac_write_sel = sel; ac_is_load = ld; ac_is_store = st; ac_is_wb = wb;
    ac_mem_size = size; ac_mem_uns = uns; ALU_result = res; ac_store_data = sdata;
    stall_cnt = 0; req_cnt = 0; cyc = 0; done = 1'b0;
    while (!done && cyc < 100) begin
      dmem_ack   = dmem_req && (req_cnt == lat);
      dmem_rdata = dmem_ack ? rdata : $urandom();
      #1;
      if (dmem_req) begin
        if (req_cnt == 0) begin
          check_eq("req_addr", dmem_addr, res & 32'hFFFF_FFFC);
          check_eq("req_we", 32'(dmem_we), 32'(st));
          if (st) begin
            check_eq("req_be", 32'(dmem_be), 32'(be_model(size, a)));
            check_eq("req_wdata", dmem_wdata, wdata_model(size, sdata));
          end
        end
        req_cnt++;
      end
      if (mem_stall) stall_cnt++;
      else done = 1'b1;
      @(posedge clock); #1;
      cyc++;
    end
    dmem_ack = 1'b0;
    check_eq("op_done", 32'(done), 32'd1);
    check_eq("stall_cycles", 32'(stall_cnt), 32'(exp_cnt));
    check_eq("req_cycles", 32'(req_cnt), 32'(exp_cnt));

    if (!mem) begin
      check_eq("alu_pc", cw_pc, pc);
      check_eq("alu_sel", 32'(cw_write_sel), 32'(sel));
      check_eq("alu_wb", 32'(cw_is_wb), 32'(wb));
      check_eq("alu_result", cw_result, res);
      check_eq("alu_err", 32'(cw_err), 32'd0);
    end else if (mis) begin
      check_eq("mis_flag", 32'(cw_misalign), 32'd1);
      check_eq("mis_wb", 32'(cw_is_wb), 32'd0);
      check_eq("mis_err", 32'(cw_err), 32'd0);
    end else if (timed_out) begin
      check_eq("to_err", 32'(cw_err), 32'd1);
      check_eq("to_wb", 32'(cw_is_wb), 32'd0);
      check_eq("to_req_drop", 32'(dmem_req), 32'd0);
    end else begin
      check_eq("mem_pc", cw_pc, pc);
      check_eq("mem_sel", 32'(cw_write_sel), 32'(sel));
      check_eq("mem_wb", 32'(cw_is_wb), 32'(wb & ld));
      check_eq("mem_err", 32'(cw_err), 32'd0);
      if (ld) check_eq("load_result", cw_result, load_model(rdata, size, a, uns));
    end

    // Idle follow-up with a stray ack, which the stage must ignore
    npc = $urandom() | 32'h4; nres = $urandom() | 32'h1; nsel = 5'($urandom());
    ac_pc = npc; ac_write_sel = nsel; ac_is_load = 1'b0; ac_is_store = 1'b0; ac_is_wb = 1'b0;
    ALU_result = nres;
    dmem_ack = 1'($urandom_range(0, 1));
    #1;
    check_eq("idle_req", 32'(dmem_req), 32'd0);
    check_eq("idle_stall", 32'(mem_stall), 32'd0);
    @(posedge clock); #1;
    dmem_ack = 1'b0;
    check_eq("pulse_err", 32'(cw_err), 32'd0);
    check_eq("pulse_mis", 32'(cw_misalign), 32'd0);
    check_eq("idle_pc", cw_pc, npc);
    check_eq("idle_result", cw_result, nres);
    check_eq("idle_wb", 32'(cw_is_wb), 32'd0);
  endtask

  initial begin
    int kind, lat;
    logic [1:0] sz;
    reset = 1'b0;
    ac_pc = '0; ac_write_sel = '0; ac_is_load = 1'b0; ac_is_store = 1'b0; ac_is_wb = 1'b0;
    ac_mem_size = '0; ac_mem_uns = 1'b0; ALU_result = '0; ac_store_data = '0;
    dmem_ack = 1'b0; dmem_rdata = '0;
    #1;
    check_eq("rst_req", 32'(dmem_req), 32'd0);
    check_eq("rst_stall", 32'(mem_stall), 32'd0);
    check_eq("rst_cw_pc", cw_pc, 32'd0);
    check_eq("rst_cw_wb", 32'(cw_is_wb), 32'd0);
    check_eq("rst_cw_result", cw_result, 32'd0);
    check_eq("rst_err", 32'(cw_err), 32'd0);
    check_eq("rst_mis", 32'(cw_misalign), 32'd0);
    #11 reset = 1'b1;
    @(posedge clock); #1;

    do_op(32'h40, 5'd5, 1'b0, 1'b0, 1'b1, SZ_W, 1'b0, 32'h1234, 32'h0, NO_ACK, 32'h0);
    do_op(32'h44, 5'd6, 1'b1, 1'b0, 1'b1, SZ_B, 1'b0, 32'h103, 32'h0, 3, 32'h80AA_BBCC);
    do_op(32'h48, 5'd7, 1'b0, 1'b1, 1'b1, SZ_H, 1'b0, 32'h202, 32'h0000_BEEF, 2, 32'h0);
    do_op(32'h4C, 5'd8, 1'b1, 1'b0, 1'b1, SZ_W, 1'b0, 32'h300, 32'h0, NO_ACK, 32'h0);
    do_op(32'h50, 5'd9, 1'b1, 1'b0, 1'b1, SZ_W, 1'b0, 32'h101, 32'h0, 1, 32'hDEAD_BEEF);
    do_op(32'h54, 5'd10, 1'b1, 1'b0, 1'b1, SZ_H, 1'b1, 32'h402, 32'h0, int'(TO) - 1, 32'h9876_5432);

    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 2);
      sz   = 2'($urandom_range(0, 2));
      case ($urandom_range(0, 7))
        0:       lat = NO_ACK;
        1:       lat = int'(TO) - 1;
        default: lat = $urandom_range(1, 5);
      endcase
      do_op($urandom(), 5'($urandom()), kind == 1, kind == 2, 1'($urandom()), sz,
            1'($urandom()), $urandom(), $urandom(), lat, $urandom());
    end

    // Reset asserted while an access is outstanding
    ac_pc = 32'h500; ac_write_sel = 5'd9; ac_is_load = 1'b1; ac_is_store = 1'b0; ac_is_wb = 1'b1;
    ac_mem_size = SZ_W; ALU_result = 32'h600;
    @(posedge clock); #1;
    check_eq("busy_req", 32'(dmem_req), 32'd1);
    @(posedge clock); #3;
    reset = 1'b0;
    #1;
    check_eq("midrst_req", 32'(dmem_req), 32'd0);
    check_eq("midrst_stall", 32'(mem_stall), 32'd0);
    check_eq("midrst_cw_pc", cw_pc, 32'd0);
    check_eq("midrst_cw_result", cw_result, 32'd0);
    check_eq("midrst_cw_wb", 32'(cw_is_wb), 32'd0);
    ac_is_load = 1'b0; ac_is_wb = 1'b0;
    dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_F00D;
    #2 reset = 1'b1;
    @(posedge clock); #1;
    check_eq("postrst_req", 32'(dmem_req), 32'd0);
    check_eq("postrst_stall", 32'(mem_stall), 32'd0);
    check_eq("postrst_wb", 32'(cw_is_wb), 32'd0);
    check_eq("postrst_result", cw_result, 32'h600);
    dmem_ack = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
